// File: rtl/matrix_result_streamer_if.sv
// matrix_result_streamer_if: capture strobes (res_*, in_ready) and output stream (out_*, ovf, mat_count); master drives, slave is the streamer
interface matrix_result_streamer_if #(
  parameter int DATA_W = 8,
  parameter int N = 4
);
  localparam int AW = $clog2(N * N);
  logic res_we;
  logic [AW-1:0] res_addr;
  logic [DATA_W-1:0] res_data;
  logic res_done;
  logic in_ready;
  logic [DATA_W-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic out_row_end;
  logic out_last;
  logic ovf;
  logic [7:0] mat_count;
  modport master (
    output res_we, res_addr, res_data, res_done, out_ready,
    input in_ready, out_data, out_valid, out_row_end, out_last, ovf, mat_count
  );
  modport slave (
    input res_we, res_addr, res_data, res_done, out_ready,
    output in_ready, out_data, out_valid, out_row_end, out_last, ovf, mat_count
  );
endinterface

// File: rtl/matrix_result_streamer.sv
// matrix_result_streamer: ping-pong NxN capture (clk, rst, bus.res_* in / in_ready out) streamed row-major over bus.out_* valid/ready with ovf and mat_count
module matrix_result_streamer #(
  parameter int DATA_W = 8,
  parameter int N = 4
) (
  input logic clk,
  input logic rst,
  matrix_result_streamer_if.slave bus
);
  localparam int NN = N * N;
  localparam int AW = $clog2(NN);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] mem_q [2][NN];
  logic [1:0] full_q, full_d;
  logic wbank_q, wbank_d, rbank_q, rbank_d, ovf_q, ovf_d;
  logic row_end_q, row_end_d, last_q, last_d;
  logic [AW-1:0] idx_q, idx_d, nidx;
  logic [DATA_W-1:0] data_q, data_d;
  logic [7:0] mc_q, mc_d;
  logic in_ready, wr, dn, xfer, fin, load, lbank;
  always_comb begin
    in_ready = !full_q[wbank_q];
    wr = bus.res_we && in_ready;
    dn = bus.res_done && in_ready;
    xfer = state_q == STREAM && bus.out_ready;
    fin = xfer && idx_q == AW'(NN - 1);
    load = state_q == IDLE ? full_q[rbank_q] : xfer && (!fin || full_q[!rbank_q]);
    lbank = fin ? !rbank_q : rbank_q;
    nidx = (state_q == IDLE || fin) ? '0 : idx_q + 1'b1;
    full_d = full_q;
    if (fin) full_d[rbank_q] = 1'b0;
    if (dn) full_d[wbank_q] = 1'b1;
    state_d = load ? STREAM : fin ? IDLE : state_q;
    idx_d = load ? nidx : idx_q;
    data_d = load ? mem_q[lbank][nidx] : data_q;
    row_end_d = load ? (32'(nidx) % N == N - 1) : row_end_q;
    last_d = load ? nidx == AW'(NN - 1) : last_q;
    wbank_d = wbank_q ^ dn;
    rbank_d = rbank_q ^ fin;
    mc_d = mc_q + 8'(fin);
    ovf_d = ovf_q || ((bus.res_we || bus.res_done) && !in_ready);
  end
  always_ff @(posedge clk)
    if (wr) mem_q[wbank_q][bus.res_addr] <= bus.res_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      full_q <= '0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      idx_q <= '0;
      data_q <= '0;
      row_end_q <= 1'b0;
      last_q <= 1'b0;
      mc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      full_q <= full_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      idx_q <= idx_d;
      data_q <= data_d;
      row_end_q <= row_end_d;
      last_q <= last_d;
      mc_q <= mc_d;
      ovf_q <= ovf_d;
    end
  end
  assign bus.in_ready = in_ready;
  assign bus.out_valid = state_q == STREAM;
  assign bus.out_data = data_q;
  assign bus.out_row_end = row_end_q;
  assign bus.out_last = last_q;
  assign bus.ovf = ovf_q;
  assign bus.mat_count = mc_q;
endmodule

// File: tb/tb_matrix_result_streamer.sv
// tb_matrix_result_streamer: table-driven and directed-sequence checks of matrix_result_streamer
module tb_matrix_result_streamer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  matrix_result_streamer_if #(.DATA_W(8), .N(4)) bus();
  matrix_result_streamer #(.DATA_W(8), .N(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic we;
    logic [3:0] addr;
    logic [7:0] data;
    logic done;
    logic rdy;
    logic e_valid;
    logic [7:0] e_data;
    logic e_re;
    logic e_last;
    logic e_ir;
    logic [7:0] e_mc;
  } vec_t;
  vec_t tbl[34];
  int pat[4] = '{40, 27, 14, 8};
  int n_vec = 0;
  int n_err = 0;
  int exp_mc = 0;
  logic [7:0] cd[$];
  logic cre[$];
  logic cl[$];
  int ccyc[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic wr_mat(input logic [7:0] base, input bit inc);
    for (int k = 0; k < 16; k++) begin
      bus.res_we = 1'b1;
      bus.res_addr = 4'(k);
      bus.res_data = inc ? base + 8'(k) : base;
      tick();
    end
    bus.res_we = 1'b0;
    bus.res_done = 1'b1;
    tick();
    bus.res_done = 1'b0;
  endtask
  task automatic collect(input int n, input bit bp, input int maxc, input bit chk_ir);
    int cyc = 0;
    int got = 0;
    logic stall = 1'b0;
    logic [9:0] held = '0;
    bit seen_last = 0;
    bit after = 0;
    cd.delete();
    cre.delete();
    cl.delete();
    ccyc.delete();
    while (got < n && cyc < maxc) begin
      bus.out_ready = bp ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
      if (after) begin
        chk("in_ready_after_free", 32'(bus.in_ready), 1);
        after = 0;
      end
      if (stall) begin
        chk("stall_valid", 32'(bus.out_valid), 1);
        chk("stall_hold", 32'({bus.out_row_end, bus.out_last, bus.out_data}), 32'(held));
      end
      if (bus.out_valid && bus.out_ready) begin
        cd.push_back(bus.out_data);
        cre.push_back(bus.out_row_end);
        cl.push_back(bus.out_last);
        ccyc.push_back(cyc);
        got++;
        if (chk_ir && bus.out_last && !seen_last) begin
          chk("in_ready_before_free", 32'(bus.in_ready), 0);
          seen_last = 1;
          after = 1;
        end
      end
      stall = bus.out_valid && !bus.out_ready;
      held = {bus.out_row_end, bus.out_last, bus.out_data};
      tick();
      cyc++;
    end
    bus.out_ready = 1'b0;
    chk("transfer_count", got, n);
  endtask
  task automatic chk_mat(input int off, input logic [7:0] base, input int mode);
    logic [7:0] e;
    for (int k = 0; k < 16; k++) begin
      if (off + k < cd.size()) begin
        e = mode == 0 ? base : mode == 1 ? base + 8'(k) : (k == 15 ? 8'd99 : base);
        chk("mat_data", 32'(cd[off + k]), 32'(e));
        chk("mat_row_end", 32'(cre[off + k]), 32'(k % 4 == 3));
        chk("mat_last", 32'(cl[off + k]), 32'(k == 15));
      end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required end before 200000");
    $fatal(1);
  end
  initial begin
    for (int k = 0; k < 34; k++) begin
      int idx;
      idx = k - 17;
      tbl[k].we = k < 16;
      tbl[k].addr = 4'(k);
      tbl[k].data = 8'(pat[k % 4]);
      tbl[k].done = k == 16;
      tbl[k].rdy = 1'b1;
      tbl[k].e_valid = k >= 17 && k <= 32;
      tbl[k].e_data = tbl[k].e_valid ? 8'(pat[idx % 4]) : 8'd0;
      tbl[k].e_re = tbl[k].e_valid && idx % 4 == 3;
      tbl[k].e_last = idx == 15;
      tbl[k].e_ir = 1'b1;
      tbl[k].e_mc = k == 33 ? 8'd1 : 8'd0;
    end
    bus.res_we = 1'b0;
    bus.res_addr = '0;
    bus.res_data = '0;
    bus.res_done = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_data", 32'(bus.out_data), 0);
    chk("rst_row_end", 32'(bus.out_row_end), 0);
    chk("rst_last", 32'(bus.out_last), 0);
    chk("rst_ovf", 32'(bus.ovf), 0);
    chk("rst_mat_count", 32'(bus.mat_count), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    for (int k = 0; k < 34; k++) begin
      bus.res_we = tbl[k].we;
      bus.res_addr = tbl[k].addr;
      bus.res_data = tbl[k].data;
      bus.res_done = tbl[k].done;
      bus.out_ready = tbl[k].rdy;
      tick();
      chk("tbl_valid", 32'(bus.out_valid), 32'(tbl[k].e_valid));
      chk("tbl_in_ready", 32'(bus.in_ready), 32'(tbl[k].e_ir));
      chk("tbl_mat_count", 32'(bus.mat_count), 32'(tbl[k].e_mc));
      if (tbl[k].e_valid) begin
        chk("tbl_data", 32'(bus.out_data), 32'(tbl[k].e_data));
        chk("tbl_row_end", 32'(bus.out_row_end), 32'(tbl[k].e_re));
        chk("tbl_last", 32'(bus.out_last), 32'(tbl[k].e_last));
      end
    end
    bus.res_we = 1'b0;
    bus.res_done = 1'b0;
    bus.out_ready = 1'b0;
    exp_mc = 1;
    wr_mat(8'd100, 1);
    collect(16, 1, 200, 0);
    chk_mat(0, 8'd100, 1);
    tick();
    chk("bp_valid_after", 32'(bus.out_valid), 0);
    exp_mc = 2;
    chk("bp_mat_count", 32'(bus.mat_count), exp_mc);
    wr_mat(8'd1, 0);
    wr_mat(8'd2, 0);
    chk("pp_in_ready_full", 32'(bus.in_ready), 0);
    collect(32, 0, 100, 0);
    chk_mat(0, 8'd1, 0);
    chk_mat(16, 8'd2, 0);
    if (ccyc.size() == 32) chk("pp_no_gap", ccyc[31] - ccyc[0], 31);
    exp_mc = 4;
    chk("pp_mat_count", 32'(bus.mat_count), exp_mc);
    chk("ovf_clear_before", 32'(bus.ovf), 0);
    wr_mat(8'd10, 1);
    wr_mat(8'd50, 1);
    chk("ovf_in_ready_full", 32'(bus.in_ready), 0);
    bus.res_we = 1'b1;
    bus.res_addr = 4'd0;
    bus.res_data = 8'd77;
    bus.res_done = 1'b1;
    tick();
    bus.res_we = 1'b0;
    bus.res_done = 1'b0;
    chk("ovf_set", 32'(bus.ovf), 1);
    chk("ovf_in_ready", 32'(bus.in_ready), 0);
    collect(32, 0, 100, 1);
    chk_mat(0, 8'd10, 1);
    chk_mat(16, 8'd50, 1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("ovf_no_third", 32'(bus.out_valid), 0);
    end
    bus.out_ready = 1'b0;
    exp_mc = 6;
    chk("ovf_mat_count", 32'(bus.mat_count), exp_mc);
    chk("ovf_sticky", 32'(bus.ovf), 1);
    for (int k = 0; k < 15; k++) begin
      bus.res_we = 1'b1;
      bus.res_addr = 4'(k);
      bus.res_data = 8'd5;
      tick();
    end
    bus.res_addr = 4'd15;
    bus.res_data = 8'd99;
    bus.res_done = 1'b1;
    tick();
    bus.res_we = 1'b0;
    bus.res_done = 1'b0;
    collect(16, 0, 100, 0);
    chk_mat(0, 8'd5, 2);
    exp_mc = 7;
    chk("same_mat_count", 32'(bus.mat_count), exp_mc);
    wr_mat(8'd20, 1);
    collect(6, 0, 100, 0);
    chk("mid_valid", 32'(bus.out_valid), 1);
    chk("mid_idx6_data", 32'(bus.out_data), 26);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_mat_count", 32'(bus.mat_count), 0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 1);
    chk("mid_rst_ovf", 32'(bus.ovf), 0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mid_no_partial", 32'(bus.out_valid), 0);
    end
    bus.out_ready = 1'b0;
    wr_mat(8'd200, 1);
    collect(16, 0, 100, 0);
    chk_mat(0, 8'd200, 1);
    chk("fresh_mat_count", 32'(bus.mat_count), 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
